// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_unit_pkg
//  Brief   : Opcode nibbles and fetch FSM encodings shared by fetch and decode.
//  Revision: 1.0
// ============================================================================
package fetch_unit_pkg;

    localparam logic [3:0] C_OP_NOP = 4'h0;
    localparam logic [3:0] C_OP_INC = 4'h1;
    localparam logic [3:0] C_OP_DEC = 4'h2;
    localparam logic [3:0] C_OP_ADN = 4'h3;
    localparam logic [3:0] C_OP_CLR = 4'hC;
    localparam logic [3:0] C_OP_JMP = 4'hA;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    localparam logic [7:0] C_RESET_PC = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_OPR = 3'd2,
        ST_HOLD      = 3'd3,
        ST_HALTED    = 3'd4
    } fetch_state_t;

    function automatic logic op_is(input logic [7:0] opcode, input logic [3:0] nibble);
        return opcode[7:4] == nibble;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_counter.sv
`default_nettype none
// ============================================================================
//  Module  : pc_counter
//  Brief   : 8-bit program counter with load / increment / hold (mod 256).
//  Revision: 1.0
// ============================================================================
module pc_counter #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_inc,
    input  logic [7:0] i_load_val,
    output logic [7:0] o_pc
);

    logic [7:0] r_pc;

    // Load wins over increment so a redirect can preempt an in-flight fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + 8'd1;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_unit
//  Brief   : Instruction fetch stage: PC, ROM strobes, instruction latch, JMP/HLT.
//  Revision: 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [7:0] RESET_PC = C_RESET_PC,
    parameter logic [3:0] OP_JMP   = C_OP_JMP,
    parameter logic [3:0] OP_HLT   = C_OP_HLT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] rom_addr,
    output logic       rom_read,
    output logic       rom_ena,
    input  logic [7:0] rom_data,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic [7:0] ir_opcode,
    output logic [7:0] ir_operand,
    output logic [7:0] ir_pc,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_addr,
    output logic       halted
);

    fetch_state_t r_state;
    logic         r_rom_ena;
    logic         r_ir_valid;
    logic [7:0]   r_ir_opcode;
    logic [7:0]   r_ir_operand;
    logic [7:0]   r_ir_pc;
    logic         r_halted;

    logic [7:0]   w_pc;
    logic         w_pc_load;
    logic         w_pc_inc;
    logic [7:0]   w_pc_load_val;

    // A redirect loads the PC from any state, including IDLE.
    always_comb begin
        w_pc_load     = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_load_val = redirect_addr;
        if (redirect_valid) begin
            w_pc_load = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH_OP:  w_pc_inc = 1'b1;
                ST_FETCH_OPR: begin
                    w_pc_load     = 1'b1;
                    w_pc_load_val = rom_data;
                end
                default: ;
            endcase
        end
    end

    pc_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_pc_load),
        .i_inc      (w_pc_inc),
        .i_load_val (w_pc_load_val),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rom_ena    <= 1'b0;
            r_ir_valid   <= 1'b0;
            r_ir_opcode  <= 8'h00;
            r_ir_operand <= 8'h00;
            r_ir_pc      <= 8'h00;
            r_halted     <= 1'b0;
        end else if (redirect_valid && r_state != ST_IDLE) begin
            r_state    <= ST_FETCH_OP;
            r_rom_ena  <= 1'b1;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state   <= ST_FETCH_OP;
                    r_rom_ena <= 1'b1;
                end
                ST_FETCH_OP: begin
                    r_ir_opcode  <= rom_data;
                    r_ir_pc      <= w_pc;
                    r_ir_operand <= 8'h00;
                    if (op_is(rom_data, OP_JMP)) begin
                        r_state <= ST_FETCH_OPR;
                    end else begin
                        r_state    <= ST_HOLD;
                        r_rom_ena  <= 1'b0;
                        r_ir_valid <= 1'b1;
                    end
                end
                ST_FETCH_OPR: begin
                    r_ir_operand <= rom_data;
                    r_state      <= ST_HOLD;
                    r_rom_ena    <= 1'b0;
                    r_ir_valid   <= 1'b1;
                end
                ST_HOLD: begin
                    if (ir_ready) begin
                        r_ir_valid <= 1'b0;
                        if (op_is(r_ir_opcode, OP_HLT)) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state   <= ST_FETCH_OP;
                            r_rom_ena <= 1'b1;
                        end
                    end
                end
                ST_HALTED: ;
                default: begin
                    r_state    <= ST_IDLE;
                    r_rom_ena  <= 1'b0;
                    r_ir_valid <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr   = w_pc;
    assign rom_read   = r_rom_ena;
    assign rom_ena    = r_rom_ena;
    // Masking keeps the decoder from accepting a wrong-path instruction.
    assign ir_valid   = r_ir_valid & ~redirect_valid;
    assign ir_opcode  = r_ir_opcode;
    assign ir_operand = r_ir_operand;
    assign ir_pc      = r_ir_pc;
    assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fetch_unit
//  Brief   : Directed bench for fetch_unit with a behavioural ROM and decoder.
//  Revision: 1.0
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        int         ph;
        logic [7:0] op;
        logic [7:0] opr;
        logic [7:0] pc;
    } ivec_t;

    typedef struct {
        int         ph;
        logic [7:0] a;
    } avec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rom_addr;
    logic       rom_read;
    logic       rom_ena;
    wire  [7:0] rom_data;
    logic       ir_valid;
    logic       ir_ready;
    logic [7:0] ir_opcode;
    logic [7:0] ir_operand;
    logic [7:0] ir_pc;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       halted;

    logic [7:0] rom [256];
    ivec_t      iexp [17];
    avec_t      aexp [22];
    ivec_t      iq [$];
    logic [7:0] fq [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_ena ? rom[rom_addr] : 8'hzz;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_read       (rom_read),
        .rom_ena        (rom_ena),
        .rom_data       (rom_data),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir_opcode      (ir_opcode),
        .ir_operand     (ir_operand),
        .ir_pc          (ir_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halted         (halted)
    );

    // Decoder/ROM observer: records accepted instructions and opcode/operand fetches.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_ena) fq.push_back(rom_addr);
            if (ir_valid && ir_ready) iq.push_back('{0, ir_opcode, ir_operand, ir_pc});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_halted(input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic compare_phase(input int ph);
        int k;
        logic [31:0] got;
        k = 0;
        for (int i = 0; i < 17; i++) begin
            if (iexp[i].ph == ph) begin
                got = (k < iq.size()) ? {8'h00, iq[k].op, iq[k].opr, iq[k].pc} : 32'hFFFF_FFFF;
                chk($sformatf("instr_p%0d_%0d", ph, k), got, {8'h00, iexp[i].op, iexp[i].opr, iexp[i].pc});
                k++;
            end
        end
        chk($sformatf("instr_count_p%0d", ph), iq.size(), k);
        k = 0;
        for (int i = 0; i < 22; i++) begin
            if (aexp[i].ph == ph) begin
                got = (k < fq.size()) ? {24'd0, fq[k]} : 32'hFFFF_FFFF;
                chk($sformatf("fetch_addr_p%0d_%0d", ph, k), got, {24'd0, aexp[i].a});
                k++;
            end
        end
        chk($sformatf("fetch_count_p%0d", ph), fq.size(), k);
    endtask

    initial begin
        int bad;

        iexp[0]  = '{1, 8'h00, 8'h00, 8'h00};
        iexp[1]  = '{1, 8'h81, 8'h00, 8'h01};
        iexp[2]  = '{1, 8'hA0, 8'h07, 8'h02};
        iexp[3]  = '{1, 8'hA3, 8'h0F, 8'h07};
        iexp[4]  = '{1, 8'h81, 8'h00, 8'h0F};
        iexp[5]  = '{1, 8'h10, 8'h00, 8'h10};
        iexp[6]  = '{1, 8'hF0, 8'h00, 8'h11};
        iexp[7]  = '{2, 8'h81, 8'h00, 8'hFF};
        iexp[8]  = '{2, 8'h00, 8'h00, 8'h00};
        iexp[9]  = '{2, 8'h81, 8'h00, 8'h01};
        iexp[10] = '{2, 8'hA0, 8'h07, 8'h02};
        iexp[11] = '{2, 8'hA3, 8'h0F, 8'h07};
        iexp[12] = '{2, 8'h81, 8'h00, 8'h0F};
        iexp[13] = '{2, 8'h10, 8'h00, 8'h10};
        iexp[14] = '{2, 8'hF0, 8'h00, 8'h11};
        iexp[15] = '{3, 8'hA0, 8'h11, 8'hFF};
        iexp[16] = '{3, 8'hF0, 8'h00, 8'h11};

        aexp[0]  = '{1, 8'h00}; aexp[1]  = '{1, 8'h01}; aexp[2]  = '{1, 8'h02};
        aexp[3]  = '{1, 8'h03}; aexp[4]  = '{1, 8'h07}; aexp[5]  = '{1, 8'h08};
        aexp[6]  = '{1, 8'h0F}; aexp[7]  = '{1, 8'h10}; aexp[8]  = '{1, 8'h11};
        aexp[9]  = '{2, 8'hFF}; aexp[10] = '{2, 8'h00}; aexp[11] = '{2, 8'h01};
        aexp[12] = '{2, 8'h02}; aexp[13] = '{2, 8'h03}; aexp[14] = '{2, 8'h07};
        aexp[15] = '{2, 8'h08}; aexp[16] = '{2, 8'h0F}; aexp[17] = '{2, 8'h10};
        aexp[18] = '{2, 8'h11};
        aexp[19] = '{3, 8'hFF}; aexp[20] = '{3, 8'h00}; aexp[21] = '{3, 8'h11};

        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[8'h00] = 8'h00; rom[8'h01] = 8'h81; rom[8'h02] = 8'hA0; rom[8'h03] = 8'h07;
        rom[8'h07] = 8'hA3; rom[8'h08] = 8'h0F; rom[8'h0F] = 8'h81; rom[8'h10] = 8'h10;
        rom[8'h11] = 8'hF0; rom[8'hFF] = 8'h81;

        rst_n          = 1'b0;
        ir_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;

        // Reset values and IDLE cycle
        #12;
        chk("reset_outputs", {rom_addr, rom_read, rom_ena, ir_valid, halted, ir_opcode, ir_pc},
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        chk("reset_operand", {24'd0, ir_operand}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_rom_ena", {31'd0, rom_ena}, 32'd0);
        @(posedge clk); #1;
        chk("first_fetch", {23'd0, rom_ena, rom_addr}, {23'd0, 1'b1, 8'h00});

        // Straight-line code, JMP and HLT
        wait_halted(100);
        compare_phase(1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rom_ena || !halted || ir_valid) bad++;
        end
        chk("halted_quiet_20", bad, 0);

        // Restart from halt, then stall the decoder
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h01;
        ir_ready       = 1'b0;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("restart_fetch", {22'd0, halted, rom_ena, rom_addr}, {22'd0, 1'b0, 1'b1, 8'h01});
        @(posedge clk); #1;
        chk("stall_first", {15'd0, ir_valid, ir_opcode, ir_pc}, {15'd0, 1'b1, 8'h81, 8'h01});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_cycle_%0d", i), {6'd0, ir_valid, rom_ena, ir_opcode, ir_pc, rom_addr},
                {6'd0, 1'b1, 1'b0, 8'h81, 8'h01, 8'h02});
        end

        // Redirect collides with ready: held instruction dropped, wrap at FF
        @(posedge clk); #1;
        ir_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 8'hFF;
        iq.delete();
        fq.delete();
        #1;
        chk("redirect_masks_valid", {31'd0, ir_valid}, 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("redirect_fetch", {23'd0, rom_ena, rom_addr}, {23'd0, 1'b1, 8'hFF});
        wait_halted(200);
        compare_phase(2);

        // JMP at FF takes its operand from 00
        rom[8'hFF] = 8'hA0;
        rom[8'h00] = 8'h11;
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        iq.delete();
        fq.delete();
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_halted(100);
        compare_phase(3);

        // Reset asserted in FETCH_OPR
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_fetch_opr", {23'd0, rom_ena, rom_addr}, {23'd0, 1'b1, 8'h00});
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {rom_addr, rom_read, rom_ena, ir_valid, halted, ir_opcode, ir_pc},
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        chk("midrst_operand", {24'd0, ir_operand}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
